// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC bus-cycle stage: state encoding, RTC register
// map and the per-state pin pattern helper.
package rtc_pkg;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_A_SETUP = 4'd1,
        ST_A_PULSE = 4'd2,
        ST_A_HOLD  = 4'd3,
        ST_GAP     = 4'd4,
        ST_D_SETUP = 4'd5,
        ST_D_PULSE = 4'd6,
        ST_D_HOLD  = 4'd7,
        ST_DONE    = 4'd8
    } state_t;

    localparam logic [7:0] SEG    = 8'h21;
    localparam logic [7:0] MIN    = 8'h22;
    localparam logic [7:0] HORA   = 8'h23;
    localparam logic [7:0] DIA    = 8'h24;
    localparam logic [7:0] MES    = 8'h25;
    localparam logic [7:0] ANO    = 8'h26;
    localparam logic [7:0] T_SEG  = 8'h41;
    localparam logic [7:0] T_MIN  = 8'h42;
    localparam logic [7:0] T_HORA = 8'h43;
    localparam logic [7:0] CMD    = 8'hF0;

    localparam logic RW_READ = 1'b1;

    typedef struct packed {
        logic ado;
        logic cso;
        logic rdo;
        logic wro;
        logic oe;
        logic sel_wdata;
    } pins_t;

    // Pin levels for the cycle spent in state s; the address always goes out with WRO.
    function automatic pins_t pins_for(state_t s, logic rd);
        pins_t p;
        p = '{ado: 1'b1, cso: 1'b1, rdo: 1'b1, wro: 1'b1, oe: 1'b0, sel_wdata: 1'b0};
        case (s)
            ST_A_SETUP, ST_A_HOLD: begin
                p.ado = 1'b0;
                p.oe  = 1'b1;
            end
            ST_A_PULSE: begin
                p.ado = 1'b0;
                p.oe  = 1'b1;
                p.cso = 1'b0;
                p.wro = 1'b0;
            end
            ST_D_SETUP, ST_D_HOLD: begin
                p.oe        = ~rd;
                p.sel_wdata = 1'b1;
            end
            ST_D_PULSE: begin
                p.cso       = 1'b0;
                p.rdo       = ~rd;
                p.wro       = rd;
                p.oe        = ~rd;
                p.sel_wdata = 1'b1;
            end
            default: ;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/rtc_phase_timer.sv
// Loadable down-counter timing each bus phase; tc_o flags the last cycle of a phase.
module rtc_phase_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             tc_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/rtc_bus_cycle.sv
// Physical RTC bus stage: turns one request into a multiplexed address/data
// cycle on Bus_Dato_Dir with fully registered strobes and bus enable.
module rtc_bus_cycle
    import rtc_pkg::*;
#(
    parameter int T_SETUP = 2,
    parameter int T_PULSE = 4,
    parameter int T_HOLD  = 2,
    parameter int T_GAP   = 2,
    parameter int CNT_W   = 4
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic       req,
    input  logic       rw,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       ADO,
    output logic       CSO,
    output logic       RDO,
    output logic       WRO,
    inout  wire  [7:0] Bus_Dato_Dir,
    output logic [3:0] dbg_state_o
);

    localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] LD_PULSE = CNT_W'(T_PULSE - 1);
    localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(T_HOLD - 1);
    localparam logic [CNT_W-1:0] LD_GAP   = CNT_W'(T_GAP - 1);

    state_t           state_q, state_d;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_tc;
    pins_t            pins_d;

    logic       rw_q;
    logic [7:0] addr_q, wdata_q, dout_q, rdata_q;
    logic       ado_q, cso_q, rdo_q, wro_q, bus_oe_q, busy_q, done_q;

    rtc_phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk_i      (CLK),
        .rst_ni     (Reset),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .tc_o       (tmr_tc)
    );

    // Every state change reloads the timer with the new phase length minus one.
    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state_q)
            ST_IDLE:    if (req)    begin state_d = ST_A_SETUP; tmr_load = 1'b1; tmr_val = LD_SETUP; end
            ST_A_SETUP: if (tmr_tc) begin state_d = ST_A_PULSE; tmr_load = 1'b1; tmr_val = LD_PULSE; end
            ST_A_PULSE: if (tmr_tc) begin state_d = ST_A_HOLD;  tmr_load = 1'b1; tmr_val = LD_HOLD;  end
            ST_A_HOLD:  if (tmr_tc) begin state_d = ST_GAP;     tmr_load = 1'b1; tmr_val = LD_GAP;   end
            ST_GAP:     if (tmr_tc) begin state_d = ST_D_SETUP; tmr_load = 1'b1; tmr_val = LD_SETUP; end
            ST_D_SETUP: if (tmr_tc) begin state_d = ST_D_PULSE; tmr_load = 1'b1; tmr_val = LD_PULSE; end
            ST_D_PULSE: if (tmr_tc) begin state_d = ST_D_HOLD;  tmr_load = 1'b1; tmr_val = LD_HOLD;  end
            ST_D_HOLD:  if (tmr_tc) begin state_d = ST_DONE;    tmr_load = 1'b1; end
            ST_DONE:    begin state_d = ST_IDLE; tmr_load = 1'b1; end
            default:    begin state_d = ST_IDLE; tmr_load = 1'b1; end
        endcase
        pins_d = pins_for(state_d, rw_q == RW_READ);
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q  <= ST_IDLE;
            rw_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            dout_q   <= '0;
            rdata_q  <= '0;
            ado_q    <= 1'b1;
            cso_q    <= 1'b1;
            rdo_q    <= 1'b1;
            wro_q    <= 1'b1;
            bus_oe_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ado_q    <= pins_d.ado;
            cso_q    <= pins_d.cso;
            rdo_q    <= pins_d.rdo;
            wro_q    <= pins_d.wro;
            bus_oe_q <= pins_d.oe;
            busy_q   <= (state_d != ST_IDLE);
            done_q   <= (state_d == ST_DONE);
            if (state_q == ST_IDLE && req) begin
                rw_q    <= rw;
                addr_q  <= addr;
                wdata_q <= wdata;
                dout_q  <= addr;
            end else begin
                dout_q  <= pins_d.sel_wdata ? wdata_q : addr_q;
            end
            // Sample on the edge that ends the read strobe.
            if (state_q == ST_D_PULSE && tmr_tc && rw_q == RW_READ) begin
                rdata_q <= Bus_Dato_Dir;
            end
        end
    end

    assign Bus_Dato_Dir = bus_oe_q ? dout_q : 8'bzzzz_zzzz;
    assign ADO          = ado_q;
    assign CSO          = cso_q;
    assign RDO          = rdo_q;
    assign WRO          = wro_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign rdata        = rdata_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_rtc_bus_cycle.sv
// Self-checking bench for rtc_bus_cycle: a per-cycle pin model derived from the
// phase lengths, randomized transactions, ignored requests, mid-cycle reset, back-to-back.
module tb_rtc_bus_cycle;

  localparam int TS = 2;
  localparam int TP = 4;
  localparam int TH = 2;
  localparam int TG = 2;
  localparam int B_AS = TS;
  localparam int B_AP = B_AS + TP;
  localparam int B_AH = B_AP + TH;
  localparam int B_GP = B_AH + TG;
  localparam int B_DS = B_GP + TS;
  localparam int B_DP = B_DS + TP;
  localparam int B_DH = B_DP + TH;
  localparam int T_DONE = B_DH + 1;
  localparam int PERIOD = T_DONE + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req = 1'b0;
  logic rw = 1'b0;
  logic [7:0] addr = 8'h00;
  logic [7:0] wdata = 8'h00;
  logic busy, done, ado, cso, rdo, wro;
  logic [7:0] rdata;
  logic [3:0] dbg_state;
  wire [7:0] bus;
  logic [7:0] tb_rval = 8'h00;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_done_cyc = -1;
  logic [7:0] rdata_model = 8'h00;

  // clock/reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // The RTC chip side: answers only while the read strobe is low.
  assign bus = (rdo == 1'b0) ? tb_rval : 8'bzzzz_zzzz;

  rtc_bus_cycle #(.T_SETUP(TS), .T_PULSE(TP), .T_HOLD(TH), .T_GAP(TG), .CNT_W(4)) dut (
    .CLK          (clk),
    .Reset        (rst_n),
    .req          (req),
    .rw           (rw),
    .addr         (addr),
    .wdata        (wdata),
    .busy         (busy),
    .done         (done),
    .rdata        (rdata),
    .ADO          (ado),
    .CSO          (cso),
    .RDO          (rdo),
    .WRO          (wro),
    .Bus_Dato_Dir (bus),
    .dbg_state_o  (dbg_state)
  );

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at cyc %0d: got %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  // Expected {ADO,CSO,RDO,WRO,bus_driven,busy,done} for cycle t after the accepting edge.
  function automatic logic [6:0] exp_ctl(input int t, input bit rd);
    if (t <= 0 || t > T_DONE) return 7'b1111_000;
    if (t <= B_AS) return 7'b0111_110;
    if (t <= B_AP) return 7'b0010_110;
    if (t <= B_AH) return 7'b0111_110;
    if (t <= B_GP) return 7'b1111_010;
    if (t <= B_DS) return {4'b1111, ~rd, 2'b10};
    if (t <= B_DP) return rd ? 7'b1001_010 : 7'b1010_110;
    if (t <= B_DH) return {4'b1111, ~rd, 2'b10};
    return 7'b1111_011;
  endfunction

  task automatic sample_idle(input string tag);
    check_eq(tag, {9'd0, ado, cso, rdo, wro, dut.bus_oe_q, busy, done}, {9'd0, 7'b1111_000});
    check_eq({tag, "_rdata"}, {8'd0, rdata}, {8'd0, rdata_model});
  endtask

  // driver task: one full bus cycle, checked every cycle against the model
  task automatic do_txn(input bit rd, input logic [7:0] a, input logic [7:0] wd,
                        input logic [7:0] rv, input bit keep_req, input bit inj_req,
                        input bit gap_chk);
    logic [6:0] ec;
    @(negedge clk);
    req = 1'b1; rw = rd; addr = a; wdata = wd; tb_rval = rv;
    @(posedge clk); #1;
    if (!keep_req) req = 1'b0;
    for (int t = 1; t <= PERIOD; t++) begin
      ec = exp_ctl(t, rd);
      if (rd && t == B_DP + 1) rdata_model = rv;
      check_eq("ctl", {9'd0, ado, cso, rdo, wro, dut.bus_oe_q, busy, done}, {9'd0, ec});
      if (ec[2]) check_eq("bus", {8'd0, bus}, {8'd0, (t <= B_AH) ? a : wd});
      check_eq("rdata", {8'd0, rdata}, {8'd0, rdata_model});
      if (t == T_DONE && done === 1'b1) begin
        if (gap_chk) check_eq("done_gap", 16'(cyc - last_done_cyc), 16'(PERIOD));
        last_done_cyc = cyc;
      end
      if (t == 5) begin
        rw = 1'($urandom_range(0, 1)); addr = 8'($urandom); wdata = 8'($urandom);
      end
      if (inj_req && t == B_AH + 1) begin req = 1'b1; addr = 8'h25; end
      if (inj_req && t == B_AH + 2) req = 1'b0;
      if (t < PERIOD) begin @(posedge clk); #1; end
    end
  endtask

  initial begin
    // reset check
    repeat (3) @(posedge clk);
    #1;
    sample_idle("reset_hold");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    sample_idle("reset_rel");
    check_eq("reset_bus_z", {15'd0, dut.bus_oe_q}, 16'd0);

    // directed write and read
    do_txn(1'b0, rtc_pkg::MIN, 8'h10, 8'h00, 1'b0, 1'b0, 1'b0);
    do_txn(1'b1, rtc_pkg::HORA, 8'hAA, 8'h08, 1'b0, 1'b0, 1'b0);
    check_eq("read_08", {8'd0, rdata}, 16'h0008);

    // ignored request during GAP: no second cycle may start
    do_txn(1'b0, rtc_pkg::SEG, 8'h5A, 8'h00, 1'b0, 1'b1, 1'b0);
    repeat (PERIOD) begin
      @(posedge clk); #1;
      sample_idle("ignored_req_idle");
    end

    // randomized transactions
    for (int i = 0; i < 6; i++) begin
      do_txn(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 8'($urandom),
             1'b0, 1'b0, 1'b0);
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
        sample_idle("rand_idle");
      end
    end

    // reset during the data strobe of a write
    @(negedge clk);
    req = 1'b1; rw = 1'b0; addr = rtc_pkg::DIA; wdata = 8'h3C;
    @(posedge clk); #1;
    req = 1'b0;
    repeat (B_DS + 1) @(posedge clk);
    #1;
    check_eq("pre_rst_wro", {15'd0, wro}, 16'd0);
    #2 rst_n = 1'b0;
    #1;
    rdata_model = 8'h00;
    sample_idle("async_rst");
    repeat (T_DONE) begin
      @(posedge clk); #1;
      check_eq("rst_no_done", {15'd0, done}, 16'd0);
    end
    @(negedge clk); rst_n = 1'b1;
    do_txn(1'b1, rtc_pkg::ANO, 8'h00, 8'h99, 1'b0, 1'b0, 1'b0);
    check_eq("post_rst_read", {8'd0, rdata}, 16'h0099);

    // back-to-back with req held high, alternating rw
    for (int i = 0; i < 4; i++) begin
      do_txn(1'(i % 2), 8'($urandom), 8'($urandom), 8'($urandom),
             (i != 3), 1'b0, (i != 0));
    end
    repeat (3) begin
      @(posedge clk); #1;
      sample_idle("final_idle");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // RDO and WRO must never be low together; CSO low must not see ADO/bus change.
  logic ado_p, cso_p;
  logic [7:0] bus_p;
  always @(negedge clk) begin
    if (rst_n) begin
      if (rdo === 1'b0 && wro === 1'b0) check_eq("rdo_wro_overlap", 16'd1, 16'd0);
      if (cso === 1'b0 && cso_p === 1'b0 && ado !== ado_p) check_eq("ado_under_cs", {15'd0, ado}, {15'd0, ado_p});
      if (cso === 1'b0 && cso_p === 1'b0 && dut.bus_oe_q && bus !== bus_p) check_eq("bus_under_cs", {8'd0, bus}, {8'd0, bus_p});
    end
    ado_p = ado; cso_p = cso; bus_p = bus;
  end

  initial begin
    #400000;
    $display("FAIL timeout at cyc %0d: got running expected finished", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rtc_bus_cycle.md
Name: rtc_bus_cycle

Overview:
- Physical-bus stage of the RTC interface. Sits directly under the register sequencer in Top_Instanciacion and drives the RTC chip pins.
- Converts one single-word request (address, write data, read/write) into a full multiplexed address/data bus cycle on Bus_Dato_Dir, with strobes ADO/CSO/RDO/WRO.
- Returns read data and a one-cycle done pulse.

Parameters:
- T_SETUP, 2, cycles the address/data is held on the bus before the strobe; must be >= 1.
- T_PULSE, 4, cycles CSO plus WRO/RDO stay low; must be >= 1.
- T_HOLD, 2, cycles after the strobe rises with the bus still driven (write/address); must be >= 1.
- T_GAP, 2, cycles between the address phase and the data phase with the bus released; must be >= 1.
- CNT_W, 4, phase counter width; must hold max(T_*) - 1.

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- req  in  1  start a cycle; sampled only in IDLE.
- rw  in  1  1 = read, 0 = write; captured with req.
- addr  in  8  RTC register address; captured with req.
- wdata  in  8  write data; captured with req.
- busy  out  1  high from the cycle after req is accepted through DONE inclusive.
- done  out  1  one-cycle pulse at end of cycle.
- rdata  out  8  last read value; updated only by reads.
- ADO  out  1  address/data select; 0 = address phase; active-low.
- CSO  out  1  chip select, active-low.
- RDO  out  1  read strobe, active-low.
- WRO  out  1  write strobe, active-low.
- Bus_Dato_Dir  inout  8  multiplexed address/data bus; tri-stated when not driven.

Behaviour:
- Clock and reset: one clock, CLK. Reset is asynchronous and active-low.
- Reset values: ADO=1, CSO=1, RDO=1, WRO=1, Bus_Dato_Dir=Z, busy=0, done=0, rdata=8'h00, state=IDLE, counter=0.
- All outputs and the bus output-enable are registered; no combinational path from inputs to pins.
- State sequence: IDLE -> A_SETUP -> A_PULSE -> A_HOLD -> GAP -> D_SETUP -> D_PULSE -> D_HOLD -> DONE -> IDLE.
- Each timed state lasts exactly its parameter count in cycles; the counter reloads on every state entry.
- IDLE: strobes high, bus Z.
  - If req=1, capture rw/addr/wdata and go to A_SETUP next cycle.
- A_SETUP (T_SETUP): ADO=0, CSO=1, WRO=1; bus drives the captured addr.
- A_PULSE (T_PULSE): ADO=0, CSO=0, WRO=0; bus drives addr. The address is always written with WRO, even for reads.
- A_HOLD (T_HOLD): ADO=0, CSO=1, WRO=1; bus still drives addr.
- GAP (T_GAP): ADO=1, all strobes high, bus Z.
- D_SETUP (T_SETUP): ADO=1, strobes high; bus drives wdata on a write, Z on a read.
- D_PULSE (T_PULSE): CSO=0; WRO=0 on a write, or RDO=0 on a read; write keeps driving wdata.
  - Read: rdata captures Bus_Dato_Dir on the last D_PULSE cycle, i.e. the edge on which RDO returns high.
- D_HOLD (T_HOLD): strobes high; write keeps driving wdata; read bus Z.
- DONE (1 cycle): done=1, busy=1, bus Z; next state IDLE.
- Latency: req accepted at edge N -> done high in cycle N+1+2*(T_SETUP+T_PULSE+T_HOLD)+T_GAP. Defaults give N+19.
- Back-to-back: req held high is re-accepted in the IDLE cycle after DONE, giving at least one idle cycle between bus cycles.
- req while not in IDLE is ignored; no queueing. Inputs changing mid-cycle have no effect (captured copies are used).
- RDO and WRO are never low in the same cycle.
- CSO low never coincides with a change of ADO or of bus contents.
- Reset asserted mid-cycle: pins return to reset values immediately (asynchronously) and no done pulse is produced. rdata is reset to 8'h00.

Decomposition:
- Shared package rtc_pkg:
  - state encoding localparams (4-bit).
  - RTC register addresses: SEG=8'h21, MIN=8'h22, HORA=8'h23, DIA=8'h24, MES=8'h25, ANO=8'h26, T_SEG=8'h41, T_MIN=8'h42, T_HORA=8'h43, CMD=8'hF0.
  - RW_READ=1'b1.
- One natural sub-module: rtc_phase_timer, a loadable down-counter with terminal-count flag.
- The tri-state driver stays in rtc_bus_cycle.

Test Plan:
- Reset check: Reset=0 for 3 cycles, then 1 -> all strobes 1, bus Z, busy=0, done=0, rdata=00 (defaults apply to all scenarios).
- Write cycle: req=1 for 1 cycle, rw=0, addr=8'h22, wdata=8'h10 ->
  - bus=22 for 8 cycles with ADO=0 and WRO/CSO low for 4 of them;
  - 2 Z cycles;
  - bus=10 for 8 cycles with WRO low for 4;
  - done at N+19; rdata unchanged.
- Read cycle: rw=1, addr=8'h23; bench drives 8'h08 onto the bus while RDO=0 -> RDO low for exactly 4 cycles, WRO stays high in the data phase, rdata=08 when done pulses.
- Ignored request: pulse req with addr=8'h25 during GAP of a write to 8'h21 -> only one done pulse; the address phase shows 21 only.
- Reset mid-operation: Reset=0 during D_PULSE of a write -> CSO/WRO go high asynchronously, bus Z, no done. After release, a new read completes normally.
- Back-to-back: req held high, alternating rw -> done pulses exactly 20 cycles apart; no overlap of CSO between cycles.
